// File: rtl/ip_header_capture.sv
// Streaming IP header assembler: captures the first HEADER_BYTES of each packet,
// holds them for a consumer handshake and forwards the payload beats with backpressure.
module ip_header_capture #(
   parameter int HEADER_BYTES = 13,
   parameter int LANE_BYTES   = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                      CLK,
   input  logic                      ARESET,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [LANE_BYTES*8-1:0]   IN_DATA,
   input  logic                      IN_LAST,
   output logic [HEADER_BYTES*8-1:0] HDR_VALUE,
   output logic                      HDR_VALID,
   input  logic                      HDR_ACK,
   output logic                      PL_VALID,
   input  logic                      PL_READY,
   output logic [LANE_BYTES*8-1:0]   PL_DATA,
   output logic                      PL_LAST,
   output logic                      RUNT,
   output logic [CNT_WIDTH-1:0]      PKT_CNT,
   output logic [CNT_WIDTH-1:0]      RUNT_CNT
);

   localparam int LANE_W = LANE_BYTES * 8;
   localparam int NBEATS = HEADER_BYTES / LANE_BYTES;
   localparam int IDX_W  = $clog2(NBEATS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

   typedef enum logic [1:0] {
      S_HDR     = 2'd0,
      S_PAYLOAD = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t                    r_state;
   logic [IDX_W-1:0]          r_idx;
   logic [HEADER_BYTES*8-1:0] r_hdr_value;
   logic                      r_hdr_valid;
   logic                      r_runt;
   logic [CNT_WIDTH-1:0]      r_pkt_cnt;
   logic [CNT_WIDTH-1:0]      r_runt_cnt;

   logic w_in_ready;
   logic w_pl_valid;
   logic w_pl_last;
   logic w_accept;
   logic w_last_hdr_beat;
   logic w_hdr_release;

   assign w_accept        = IN_VALID && w_in_ready;
   assign w_last_hdr_beat = (r_idx == LAST_IDX);
   assign w_hdr_release   = !r_hdr_valid || HDR_ACK;

   // Handshake steering; the payload path stays combinational so it adds no latency.
   always_comb begin
      w_in_ready = 1'b0;
      w_pl_valid = 1'b0;
      w_pl_last  = 1'b0;
      case (r_state)
         S_HDR: begin
            w_in_ready = !ARESET;
         end
         S_PAYLOAD: begin
            w_in_ready = PL_READY && !ARESET;
            w_pl_valid = IN_VALID && !ARESET;
            w_pl_last  = IN_LAST;
         end
         S_HOLD: begin
            w_in_ready = 1'b0;
         end
         default: begin
            w_in_ready = 1'b0;
         end
      endcase
   end

   // Packet FSM, header capture, header handshake and statistics.
   always_ff @(posedge CLK or posedge ARESET) begin
      if (ARESET) begin
         r_state     <= S_HDR;
         r_idx       <= '0;
         r_hdr_value <= '0;
         r_hdr_valid <= 1'b0;
         r_runt      <= 1'b0;
         r_pkt_cnt   <= '0;
         r_runt_cnt  <= '0;
      end else begin
         r_runt <= 1'b0;
         if (r_hdr_valid && HDR_ACK) begin
            r_hdr_valid <= 1'b0;
         end
         case (r_state)
            S_HDR: begin
               if (w_accept) begin
                  for (int b = 0; b < NBEATS; b++) begin
                     if (r_idx == IDX_W'(b)) begin
                        r_hdr_value[b*LANE_W +: LANE_W] <= IN_DATA;
                     end
                  end
                  if (w_last_hdr_beat) begin
                     // HDR_VALID is known low here, so a concurrent ack cannot be lost.
                     r_hdr_valid <= 1'b1;
                     r_pkt_cnt   <= r_pkt_cnt + CNT_WIDTH'(1);
                     r_idx       <= '0;
                     r_state     <= IN_LAST ? S_HOLD : S_PAYLOAD;
                  end else if (IN_LAST) begin
                     r_runt     <= 1'b1;
                     r_runt_cnt <= r_runt_cnt + CNT_WIDTH'(1);
                     r_idx      <= '0;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            S_PAYLOAD: begin
               if (w_accept && IN_LAST) begin
                  r_state <= (r_hdr_valid && !HDR_ACK) ? S_HOLD : S_HDR;
               end
            end
            S_HOLD: begin
               // Never start a new header until the previous one has been released.
               if (w_hdr_release) begin
                  r_state <= S_HDR;
               end
            end
            default: begin
               r_state <= S_HDR;
               r_idx   <= '0;
            end
         endcase
      end
   end

   assign IN_READY  = w_in_ready;
   assign PL_VALID  = w_pl_valid;
   assign PL_DATA   = IN_DATA;
   assign PL_LAST   = w_pl_last;
   assign HDR_VALUE = r_hdr_value;
   assign HDR_VALID = r_hdr_valid;
   assign RUNT      = r_runt;
   assign PKT_CNT   = r_pkt_cnt;
   assign RUNT_CNT  = r_runt_cnt;

endmodule

// File: tb/tb_ip_header_capture.sv
// Directed bench for ip_header_capture: table-driven byte-lane vectors plus
// hand-written backpressure, reset and wide-lane sequences.
module tb_ip_header_capture;

   logic         clk;
   logic         areset;
   logic         in_valid, in_ready, in_last;
   logic [7:0]   in_data;
   logic [103:0] hdr_value;
   logic         hdr_valid, hdr_ack;
   logic         pl_valid, pl_ready, pl_last;
   logic [7:0]   pl_data;
   logic         runt;
   logic [15:0]  pkt_cnt, runt_cnt;

   logic         w_in_valid, w_in_ready, w_in_last;
   logic [31:0]  w_in_data;
   logic [95:0]  w_hdr_value;
   logic         w_hdr_valid, w_hdr_ack;
   logic         w_pl_valid, w_pl_ready, w_pl_last;
   logic [31:0]  w_pl_data;
   logic         w_runt;
   logic [15:0]  w_pkt_cnt, w_runt_cnt;

   int n_checks = 0;
   int n_errors = 0;
   logic [8:0] pl_q[$];

   ip_header_capture #(.HEADER_BYTES(13), .LANE_BYTES(1), .CNT_WIDTH(16)) u_dut (
      .CLK(clk), .ARESET(areset), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_DATA(in_data), .IN_LAST(in_last), .HDR_VALUE(hdr_value), .HDR_VALID(hdr_valid),
      .HDR_ACK(hdr_ack), .PL_VALID(pl_valid), .PL_READY(pl_ready), .PL_DATA(pl_data),
      .PL_LAST(pl_last), .RUNT(runt), .PKT_CNT(pkt_cnt), .RUNT_CNT(runt_cnt)
   );

   ip_header_capture #(.HEADER_BYTES(12), .LANE_BYTES(4), .CNT_WIDTH(16)) u_wide (
      .CLK(clk), .ARESET(areset), .IN_VALID(w_in_valid), .IN_READY(w_in_ready),
      .IN_DATA(w_in_data), .IN_LAST(w_in_last), .HDR_VALUE(w_hdr_value), .HDR_VALID(w_hdr_valid),
      .HDR_ACK(w_hdr_ack), .PL_VALID(w_pl_valid), .PL_READY(w_pl_ready), .PL_DATA(w_pl_data),
      .PL_LAST(w_pl_last), .RUNT(w_runt), .PKT_CNT(w_pkt_cnt), .RUNT_CNT(w_runt_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Records every payload beat transferred by the narrow instance.
   always @(negedge clk) begin
      if (pl_valid && pl_ready) pl_q.push_back({pl_last, pl_data});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       in_valid;
      logic [7:0] in_data;
      logic       in_last;
      logic       pl_ready;
      logic       hdr_ack;
      logic       e_in_ready;
      logic       e_pl_valid;
      logic [7:0] e_pl_data;
      logic       e_pl_last;
      logic       e_hdr_valid;
      logic       e_runt;
   } vec_t;

   vec_t vecs[48];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic v, input logic [7:0] d, input logic l,
                       input logic pr, input logic ack, input logic e_rdy, input logic e_plv,
                       input logic [7:0] e_pld, input logic e_pll, input logic e_hv,
                       input logic e_runt);
      vecs[i] = '{v, d, l, pr, ack, e_rdy, e_plv, e_pld, e_pll, e_hv, e_runt};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l,
                        input logic pr, input logic ack);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      pl_ready = pr;
      hdr_ack  = ack;
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_last, vecs[i].pl_ready, vecs[i].hdr_ack);
         #1;
         chk($sformatf("in_ready[%0d]", i), {127'd0, in_ready}, {127'd0, vecs[i].e_in_ready});
         chk($sformatf("pl_valid[%0d]", i), {127'd0, pl_valid}, {127'd0, vecs[i].e_pl_valid});
         chk($sformatf("hdr_valid[%0d]", i), {127'd0, hdr_valid}, {127'd0, vecs[i].e_hdr_valid});
         chk($sformatf("runt[%0d]", i), {127'd0, runt}, {127'd0, vecs[i].e_runt});
         if (vecs[i].e_pl_valid) begin
            chk($sformatf("pl_data[%0d]", i), {120'd0, pl_data}, {120'd0, vecs[i].e_pl_data});
            chk($sformatf("pl_last[%0d]", i), {127'd0, pl_last}, {127'd0, vecs[i].e_pl_last});
         end
         step();
      end
   endtask

   initial begin
      // Basic capture with payload and an ack during the payload.
      for (int i = 0; i < 13; i++) setv(i, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      setv(13, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0);
      setv(14, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
      setv(15, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0);
      // Runt of 5 bytes, then idle cycles covering the RUNT pulse.
      for (int i = 0; i < 5; i++) setv(16 + i, 1'b1, 8'h50 + 8'(i), (i == 4), 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      setv(21, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      setv(22, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      // Header-only packet held unacknowledged for 10 cycles, then released.
      for (int i = 0; i < 13; i++) setv(23 + i, 1'b1, 8'h10 + 8'(i), (i == 12), 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) setv(36 + i, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      setv(46, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      setv(47, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      areset = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      w_in_valid = 1'b0; w_in_data = 32'd0; w_in_last = 1'b0; w_pl_ready = 1'b1; w_hdr_ack = 1'b0;
      #2;
      chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
      chk("rst_pl_valid", {127'd0, pl_valid}, 128'd0);
      chk("rst_hdr_valid", {127'd0, hdr_valid}, 128'd0);
      chk("rst_hdr_value", {24'd0, hdr_value}, 128'd0);
      chk("rst_pkt_cnt", {112'd0, pkt_cnt}, 128'd0);
      chk("rst_runt_cnt", {112'd0, runt_cnt}, 128'd0);
      step();
      step();
      areset = 1'b0;

      apply(0, 15);
      chk("basic_hdr_value", {24'd0, hdr_value}, 128'h0C0B0A09080706050403020100);
      chk("basic_pkt_cnt", {112'd0, pkt_cnt}, 128'd1);
      apply(16, 22);
      chk("runt_cnt", {112'd0, runt_cnt}, 128'd1);
      chk("runt_hdr_value", {24'd0, hdr_value}, 128'h0C0B0A09080706055453525150);
      chk("runt_pkt_cnt", {112'd0, pkt_cnt}, 128'd1);
      apply(23, 35);
      chk("post_runt_hdr_value", {24'd0, hdr_value}, 128'h1C1B1A19181716151413121110);
      chk("post_runt_pkt_cnt", {112'd0, pkt_cnt}, 128'd2);
      apply(36, 47);

      // Backpressure: PL_READY low for 3 cycles while 0xB2 is presented.
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, 8'h20 + 8'(i), 1'b0, 1'b1, 1'b0);
         step();
      end
      pl_q.delete();
      drive(1'b1, 8'hB0, 1'b0, 1'b1, 1'b1); step();
      drive(1'b1, 8'hB1, 1'b0, 1'b1, 1'b0); step();
      drive(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_in_ready[%0d]", k), {127'd0, in_ready}, 128'd0);
         chk($sformatf("bp_pl_data[%0d]", k), {120'd0, pl_data}, 128'hB2);
         step();
      end
      drive(1'b1, 8'hB2, 1'b0, 1'b1, 1'b0); step();
      drive(1'b1, 8'hB3, 1'b0, 1'b1, 1'b0); step();
      drive(1'b1, 8'hB4, 1'b1, 1'b1, 1'b0); step();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      #1;
      chk("bp_beats", 128'(pl_q.size()), 128'd5);
      for (int k = 0; k < 5; k++) begin
         logic [8:0] exp_beat;
         exp_beat = {(k == 4), 8'hB0 + 8'(k)};
         if (k < pl_q.size()) chk($sformatf("bp_beat[%0d]", k), {119'd0, pl_q[k]}, {119'd0, exp_beat});
      end
      chk("bp_done_in_ready", {127'd0, in_ready}, 128'd1);
      step();

      // Reset asserted mid-payload.
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b1, 1'b0);
         step();
      end
      drive(1'b1, 8'hC0, 1'b0, 1'b1, 1'b0); step();
      drive(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0);
      areset = 1'b1;
      #1;
      chk("mid_rst_hdr_valid", {127'd0, hdr_valid}, 128'd0);
      chk("mid_rst_pkt_cnt", {112'd0, pkt_cnt}, 128'd0);
      chk("mid_rst_pl_valid", {127'd0, pl_valid}, 128'd0);
      chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
      step();
      step();
      areset = 1'b0;
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, 8'h40 + 8'(i), (i == 12), 1'b1, 1'b0);
         step();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("post_rst_hdr_value", {24'd0, hdr_value}, 128'h4C4B4A49484746454443424140);
      chk("post_rst_hdr_valid", {127'd0, hdr_valid}, 128'd1);
      chk("post_rst_pkt_cnt", {112'd0, pkt_cnt}, 128'd1);
      chk("post_rst_hold", {127'd0, in_ready}, 128'd0);
      hdr_ack = 1'b1; step(); hdr_ack = 1'b0;
      chk("post_rst_release", {127'd0, in_ready}, 128'd1);

      // Wide lanes: 12-byte header in three 4-byte beats, two payload beats.
      w_in_valid = 1'b1;
      w_in_data = 32'h03020100; step();
      w_in_data = 32'h07060504; step();
      w_in_data = 32'h0B0A0908; step();
      w_in_data = 32'hDEADBEEF; w_in_last = 1'b0;
      #1;
      chk("wide_pl_valid0", {127'd0, w_pl_valid}, 128'd1);
      chk("wide_pl_data0", {96'd0, w_pl_data}, 128'hDEADBEEF);
      chk("wide_pl_last0", {127'd0, w_pl_last}, 128'd0);
      chk("wide_hdr_valid", {127'd0, w_hdr_valid}, 128'd1);
      step();
      w_in_data = 32'h12345678; w_in_last = 1'b1;
      #1;
      chk("wide_pl_data1", {96'd0, w_pl_data}, 128'h12345678);
      chk("wide_pl_last1", {127'd0, w_pl_last}, 128'd1);
      step();
      w_in_valid = 1'b0; w_in_last = 1'b0;
      chk("wide_hdr_value", {32'd0, w_hdr_value}, 128'h0B0A09080706050403020100);
      chk("wide_pkt_cnt", {112'd0, w_pkt_cnt}, 128'd1);
      chk("wide_hold", {127'd0, w_in_ready}, 128'd0);
      w_hdr_ack = 1'b1; step(); w_hdr_ack = 1'b0;
      chk("wide_release", {127'd0, w_in_ready}, 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ip_header_capture.md
# ip_header_capture

Parametrised receive-side header assembler for the accelerator's IP packet path. Generalises the byte-addressed write register to a streaming front end. It accepts a valid/ready byte stream of LANE_BYTES per beat and generates write indices internally. It captures the first HEADER_BYTES of each packet into a wide register, holds that register for a consumer handshake, and passes the remaining payload beats straight through with backpressure. Packets shorter than the header are detected, flagged and discarded.

## Interface
- HEADER_BYTES, 13, header length in bytes. Must be a multiple of LANE_BYTES and ≥ LANE_BYTES.
- LANE_BYTES, 1, bytes per input/output beat. Legal values: 1, 2, 4, 8.
- CNT_WIDTH, 16, width of the packet and runt statistics counters.
- CLK  in  1  clock; all state updates on the rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  input beat accepted when IN_VALID && IN_READY.
- IN_DATA  in  LANE_BYTES*8  input beat. Lane k (bits 8k+7:8k) is the k-th byte in stream order.
- IN_LAST  in  1  final beat of the packet.
- HDR_VALUE  out  HEADER_BYTES*8  captured header. Stream byte n sits at bits 8n+7:8n.
- HDR_VALID  out  1  HDR_VALUE is complete and stable.
- HDR_ACK  in  1  consumer releases the header. Ignored while HDR_VALID=0.
- PL_VALID  out  1  payload beat valid.
- PL_READY  in  1  downstream accepts the payload beat.
- PL_DATA  out  LANE_BYTES*8  payload beat, same lane order as IN_DATA.
- PL_LAST  out  1  final payload beat.
- RUNT  out  1  one-cycle pulse: a packet ended before the header was complete.
- PKT_CNT  out  CNT_WIDTH  packets with a complete header. Wraps modulo 2^CNT_WIDTH.
- RUNT_CNT  out  CNT_WIDTH  runt packets. Wraps modulo 2^CNT_WIDTH.

## Operation
- Beat index counter: width $clog2(HEADER_BYTES/LANE_BYTES+1). It writes IN_DATA to bytes [idx*LANE_BYTES +: LANE_BYTES] of HDR_VALUE.
- States: S_HDR, S_PAYLOAD, S_HOLD. The state after reset is S_HDR.
- S_HDR: IN_READY=1, PL_VALID=0. On each accepted beat, write the beat into HDR_VALUE and increment idx.
  - If the beat is the final header beat (idx = HEADER_BYTES/LANE_BYTES-1):
    - set HDR_VALID, increment PKT_CNT, clear idx;
    - if IN_LAST=0, go to S_PAYLOAD;
    - if IN_LAST=1, go to S_HOLD (header-only packet, no payload beats).
  - If IN_LAST=1 on an earlier beat: pulse RUNT, increment RUNT_CNT, clear idx, stay in S_HDR. HDR_VALID stays 0. Bytes of HDR_VALUE that were not written keep their old values.
- S_PAYLOAD: combinational pass-through with no storage.
  - PL_VALID=IN_VALID, PL_DATA=IN_DATA, PL_LAST=IN_LAST, IN_READY=PL_READY.
  - On an accepted beat with IN_LAST=1: go to S_HOLD if HDR_VALID && !HDR_ACK, else go to S_HDR.
- S_HOLD: IN_READY=0, PL_VALID=0. Go to S_HDR on the cycle HDR_VALID=0 or HDR_ACK=1.
  - This guarantees a new header never overwrites an unacknowledged one.
- HDR_VALID clears on the edge where HDR_VALID && HDR_ACK. The consumer may ack during the payload.
- Setting HDR_VALID and a HDR_ACK in the same cycle cannot collide: HDR_VALID is 0 in that cycle, so HDR_ACK is ignored.
- HDR_VALUE changes only on accepted beats in S_HDR, and therefore never while HDR_VALID=1.

## Timing
- Reset values:
  - state S_HDR, idx 0;
  - HDR_VALUE 0, HDR_VALID 0, RUNT 0, PKT_CNT 0, RUNT_CNT 0;
  - IN_READY 0 and PL_VALID 0 while ARESET is high.
- Header latency: HDR_VALID=1 in the cycle after the final header beat is accepted.
- Payload latency: zero cycles, combinational from IN_* to PL_*. PL_READY→IN_READY is also combinational.
- RUNT is high for exactly the one cycle after the runt's last beat is accepted.
- Release after an ack in S_HOLD: IN_READY=1 in the cycle after HDR_ACK is sampled.
- Back-to-back packets with an early ack: the first header beat of packet N+1 can be accepted in the cycle after packet N's last payload beat.
- Reset asserted mid-packet:
  - immediate return to reset values;
  - the partial packet is lost;
  - the first post-reset beat is treated as header byte 0.

## Test plan
- Basic capture, HEADER_BYTES=13, LANE_BYTES=1, PL_READY=1:
  - stimulus: bytes 0x00..0x0C, then payload 0xA0,0xA1,0xA2 with IN_LAST on 0xA2; ack one cycle after HDR_VALID rises;
  - required: HDR_VALUE=0x0C0B0A09080706050403020100; HDR_VALID rises the cycle after byte 0x0C; PL_DATA A0,A1,A2 with PL_LAST only on A2; PKT_CNT=1.
- Runt: 5 bytes, IN_LAST on the 5th.
  - Required: RUNT pulses 1 cycle, RUNT_CNT=1, HDR_VALID stays 0, no PL_VALID.
  - A following 13-byte packet 0x10..0x1C is then captured correctly.
- Header-only packet: 13 bytes with IN_LAST on the 13th; HDR_ACK held 0 for 10 cycles.
  - Required: PL_VALID never asserted; IN_READY=0 for those 10 cycles; IN_READY=1 the cycle after the ack.
- Backpressure: PL_READY=0 for 3 cycles mid-payload.
  - Required: IN_READY=0 for those 3 cycles, PL_DATA holds the stalled byte, all payload bytes delivered in order with none dropped.
- Wide lanes, HEADER_BYTES=12, LANE_BYTES=4:
  - stimulus: header beats 0x03020100, 0x07060504, 0x0B0A0908, then 2 payload beats;
  - required: HDR_VALUE=0x0B0A09080706050403020100 and both payload beats passed through unchanged.
- Reset mid-payload: assert ARESET for 2 cycles during the payload.
  - Required: HDR_VALID=0, PKT_CNT=0, PL_VALID=0.
  - A subsequent full packet is captured from byte 0.
